// File: rtl/icache_refill_ctrl_pkg.sv
// ============================================================================
// Module   : icache_refill_ctrl_pkg
// Brief    : Shared types and default geometry for the icache refill path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_refill_ctrl_pkg;

    localparam int c_icache_num_set      = 64;
    localparam int c_icache_ways_per_set = 4;
    localparam int c_thr_per_core        = 4;
    localparam int c_phy_addr_width      = 32;
    localparam int c_icache_line_width   = 512;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } refill_state_t;

    typedef enum logic {
        SINGLE_THREADED = 1'b0,
        MULTI_THREADED  = 1'b1
    } multithreading_mode_t;

    // Byte-offset width of a line; the set field sits directly above it.
    function automatic int line_offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_refill_ctrl_rr_arbiter.sv
// ============================================================================
// Module   : icache_refill_ctrl_rr_arbiter
// Brief    : Round-robin arbiter; request vector to one-hot grant, pointer
//            moves past the winner when advance_i is high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_ctrl_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        cand          = '0;
        found         = 1'b0;
        grant_o       = '0;
        grant_idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N);
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                found         = 1'b1;
            end
        end
        grant_valid_o = found;
        ptr_d         = ptr_q;
        if (advance_i && found) begin
            ptr_d = IDX_W'((int'(grant_idx_o) + 1) % N);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// Module   : icache_refill_ctrl
// Brief    : Per-thread icache miss tracking, round-robin line requests and
//            one-cycle fill / LRU update / wake-up on each response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int NUM_SET        = c_icache_num_set,
    parameter int WAYS_PER_SET   = c_icache_ways_per_set,
    parameter int NUM_THREADS    = c_thr_per_core,
    parameter int ADDR_W         = c_phy_addr_width,
    parameter int LINE_W         = c_icache_line_width,
    parameter int NUM_SET_W      = $clog2(NUM_SET),
    parameter int WAYS_PER_SET_W = $clog2(WAYS_PER_SET),
    parameter int THR_W          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    parameter int OFFSET_W       = line_offset_w(LINE_W),
    parameter int TAG_W          = ADDR_W - NUM_SET_W - OFFSET_W
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  multithreading_mode_t      mt_mode_i,
    input  logic                      miss_valid_i,
    input  logic [THR_W-1:0]          miss_thread_i,
    input  logic [ADDR_W-1:0]         miss_addr_i,
    output logic                      miss_ready_o,
    output logic                      victim_req_o,
    output logic [NUM_SET_W-1:0]      victim_set_o,
    input  logic [WAYS_PER_SET_W-1:0] victim_way_i,
    output logic                      mem_req_valid_o,
    output logic [ADDR_W-1:0]         mem_req_addr_o,
    output logic [THR_W-1:0]          mem_req_thread_o,
    input  logic                      mem_req_ready_i,
    input  logic                      mem_rsp_valid_i,
    input  logic [THR_W-1:0]          mem_rsp_thread_i,
    input  logic [LINE_W-1:0]         mem_rsp_data_i,
    output logic                      fill_valid_o,
    output logic [NUM_SET_W-1:0]      fill_set_o,
    output logic [WAYS_PER_SET_W-1:0] fill_way_o,
    output logic [TAG_W-1:0]          fill_tag_o,
    output logic [LINE_W-1:0]         fill_data_o,
    output logic                      update_req_mt_o,
    output logic [NUM_SET_W-1:0]      update_set_mt_o,
    output logic [WAYS_PER_SET_W-1:0] update_way_mt_o,
    output logic [THR_W-1:0]          update_thread_mt_o,
    output logic [NUM_THREADS-1:0]    refill_done_o,
    output logic                      rsp_error_o
);

    refill_state_t               state_q [NUM_THREADS];
    refill_state_t               state_d [NUM_THREADS];
    logic [ADDR_W-1:0]           addr_q  [NUM_THREADS];
    logic [WAYS_PER_SET_W-1:0]   way_q   [NUM_THREADS];

    logic                        mem_req_valid_q;
    logic [ADDR_W-1:0]           mem_req_addr_q;
    logic [THR_W-1:0]            mem_req_thread_q;

    logic                        fill_valid_q;
    logic [NUM_SET_W-1:0]        fill_set_q;
    logic [WAYS_PER_SET_W-1:0]   fill_way_q;
    logic [TAG_W-1:0]            fill_tag_q;
    logic [LINE_W-1:0]           fill_data_q;
    logic [THR_W-1:0]            fill_thread_q;
    logic [NUM_THREADS-1:0]      refill_done_q;
    logic                        rsp_error_q;

    logic                        w_thread_ok;
    logic                        w_alloc;
    logic                        w_accept;
    logic                        w_rsp_hit;
    logic                        w_arb_advance;
    logic [NUM_THREADS-1:0]      w_arb_req;
    logic [NUM_THREADS-1:0]      w_arb_gnt;
    logic [THR_W-1:0]            w_arb_idx;
    logic                        w_arb_valid;
    logic [ADDR_W-1:0]           w_gnt_addr;

    // Single-threaded cores only ever refill on behalf of thread 0.
    assign w_thread_ok   = (mt_mode_i == MULTI_THREADED) || (miss_thread_i == '0);
    assign miss_ready_o  = w_thread_ok && (state_q[miss_thread_i] == ST_IDLE);
    assign victim_req_o  = miss_valid_i && miss_ready_o;
    assign victim_set_o  = miss_addr_i[OFFSET_W +: NUM_SET_W];
    assign w_alloc       = victim_req_o;
    assign w_accept      = mem_req_valid_q && mem_req_ready_i;
    assign w_rsp_hit     = mem_rsp_valid_i && (state_q[mem_rsp_thread_i] == ST_WAIT_RSP);
    assign w_arb_advance = !mem_req_valid_q && w_arb_valid;

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_arb_req
        assign w_arb_req[g] = (state_q[g] == ST_REQ);
    end

    icache_refill_ctrl_rr_arbiter #(
        .N     (NUM_THREADS),
        .IDX_W (THR_W)
    ) u_rr_arbiter (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .req_i         (w_arb_req),
        .advance_i     (w_arb_advance),
        .grant_o       (w_arb_gnt),
        .grant_idx_o   (w_arb_idx),
        .grant_valid_o (w_arb_valid)
    );

    always_comb begin
        w_gnt_addr = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (w_arb_gnt[i]) begin
                w_gnt_addr = w_gnt_addr | addr_q[i];
            end
        end
    end

    // Allocation, acceptance and response each require a different current
    // state, so at most one of them can apply to a given thread per cycle.
    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            state_d[i] = state_q[i];
            if (w_alloc && (miss_thread_i == THR_W'(i))) begin
                state_d[i] = ST_REQ;
            end
            if (w_accept && (mem_req_thread_q == THR_W'(i))) begin
                state_d[i] = ST_WAIT_RSP;
            end
            if (w_rsp_hit && (mem_rsp_thread_i == THR_W'(i))) begin
                state_d[i] = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state_q[i] <= ST_IDLE;
                addr_q[i]  <= '0;
                way_q[i]   <= '0;
            end
            mem_req_valid_q  <= 1'b0;
            mem_req_addr_q   <= '0;
            mem_req_thread_q <= '0;
            fill_valid_q     <= 1'b0;
            fill_set_q       <= '0;
            fill_way_q       <= '0;
            fill_tag_q       <= '0;
            fill_data_q      <= '0;
            fill_thread_q    <= '0;
            refill_done_q    <= '0;
            rsp_error_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state_q[i] <= state_d[i];
            end
            if (w_alloc) begin
                addr_q[miss_thread_i] <= miss_addr_i;
                way_q[miss_thread_i]  <= victim_way_i;
            end

            if (w_arb_advance) begin
                mem_req_valid_q  <= 1'b1;
                mem_req_addr_q   <= w_gnt_addr;
                mem_req_thread_q <= w_arb_idx;
            end else if (w_accept) begin
                mem_req_valid_q  <= 1'b0;
            end

            fill_valid_q  <= w_rsp_hit;
            refill_done_q <= '0;
            if (w_rsp_hit) begin
                fill_set_q    <= addr_q[mem_rsp_thread_i][OFFSET_W +: NUM_SET_W];
                fill_way_q    <= way_q[mem_rsp_thread_i];
                fill_tag_q    <= addr_q[mem_rsp_thread_i][ADDR_W-1 -: TAG_W];
                fill_data_q   <= mem_rsp_data_i;
                fill_thread_q <= mem_rsp_thread_i;
                refill_done_q <= NUM_THREADS'(1) << mem_rsp_thread_i;
            end
            if (mem_rsp_valid_i && !w_rsp_hit) begin
                rsp_error_q <= 1'b1;
            end
        end
    end

    assign mem_req_valid_o    = mem_req_valid_q;
    assign mem_req_addr_o     = mem_req_addr_q;
    assign mem_req_thread_o   = mem_req_thread_q;
    assign fill_valid_o       = fill_valid_q;
    assign fill_set_o         = fill_set_q;
    assign fill_way_o         = fill_way_q;
    assign fill_tag_o         = fill_tag_q;
    assign fill_data_o        = fill_data_q;
    assign update_req_mt_o    = fill_valid_q;
    assign update_set_mt_o    = fill_set_q;
    assign update_way_mt_o    = fill_way_q;
    assign update_thread_mt_o = fill_thread_q;
    assign refill_done_o      = refill_done_q;
    assign rsp_error_o        = rsp_error_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
// ============================================================================
// Module   : tb_icache_refill_ctrl
// Brief    : Directed self-checking bench for icache_refill_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    multithreading_mode_t mt_mode;
    logic                 miss_valid;
    logic [1:0]           miss_thread;
    logic [31:0]          miss_addr;
    logic                 miss_ready;
    logic                 victim_req;
    logic [5:0]           victim_set;
    logic [1:0]           victim_way;
    logic                 mem_req_valid;
    logic [31:0]          mem_req_addr;
    logic [1:0]           mem_req_thread;
    logic                 mem_req_ready;
    logic                 mem_rsp_valid;
    logic [1:0]           mem_rsp_thread;
    logic [511:0]         mem_rsp_data;
    logic                 fill_valid;
    logic [5:0]           fill_set;
    logic [1:0]           fill_way;
    logic [19:0]          fill_tag;
    logic [511:0]         fill_data;
    logic                 update_req_mt;
    logic [5:0]           update_set_mt;
    logic [1:0]           update_way_mt;
    logic [1:0]           update_thread_mt;
    logic [3:0]           refill_done;
    logic                 rsp_error;

    int checks = 0;
    int errors = 0;
    int grants[$];

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clock_i            (clk),
        .reset_i            (rst),
        .mt_mode_i          (mt_mode),
        .miss_valid_i       (miss_valid),
        .miss_thread_i      (miss_thread),
        .miss_addr_i        (miss_addr),
        .miss_ready_o       (miss_ready),
        .victim_req_o       (victim_req),
        .victim_set_o       (victim_set),
        .victim_way_i       (victim_way),
        .mem_req_valid_o    (mem_req_valid),
        .mem_req_addr_o     (mem_req_addr),
        .mem_req_thread_o   (mem_req_thread),
        .mem_req_ready_i    (mem_req_ready),
        .mem_rsp_valid_i    (mem_rsp_valid),
        .mem_rsp_thread_i   (mem_rsp_thread),
        .mem_rsp_data_i     (mem_rsp_data),
        .fill_valid_o       (fill_valid),
        .fill_set_o         (fill_set),
        .fill_way_o         (fill_way),
        .fill_tag_o         (fill_tag),
        .fill_data_o        (fill_data),
        .update_req_mt_o    (update_req_mt),
        .update_set_mt_o    (update_set_mt),
        .update_way_mt_o    (update_way_mt),
        .update_thread_mt_o (update_thread_mt),
        .refill_done_o      (refill_done),
        .rsp_error_o        (rsp_error)
    );

    // Records every request handshake that will complete at the coming edge.
    task automatic tick();
        if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) grants.push_back(int'(mem_req_thread));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] line_data(input int k);
        return {16{32'hC0DE_0000 + 32'(k)}};
    endfunction

    task automatic test_reset();
        rst = 1'b1; mt_mode = MULTI_THREADED; miss_valid = 0; miss_thread = 0; miss_addr = 0;
        victim_way = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_thread = 0; mem_rsp_data = '0;
        tick(); tick();
        rst = 1'b0; #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %b exp 0", mem_req_valid); end
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL reset_fill_valid got %b exp 0", fill_valid); end
        checks++; if (update_req_mt !== 1'b0) begin errors++; $display("FAIL reset_update_req got %b exp 0", update_req_mt); end
        checks++; if (refill_done !== 4'b0) begin errors++; $display("FAIL reset_refill_done got %b exp 0000", refill_done); end
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got %b exp 0", rsp_error); end
        checks++; if (fill_data !== '0 || mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_data got addr %h exp 0", mem_req_addr); end
        for (int t = 0; t < 4; t++) begin
            miss_thread = 2'(t); #1;
            checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL reset_miss_ready thr %0d got %b exp 1", t, miss_ready); end
        end
    endtask

    task automatic test_st_basic();
        int n;
        mt_mode = SINGLE_THREADED; mem_req_ready = 1;
        miss_valid = 1; miss_thread = 1; miss_addr = 32'h1040; victim_way = 2; #1;
        checks++; if (miss_ready !== 1'b0 || victim_req !== 1'b0) begin errors++; $display("FAIL st_thread1_blocked got ready %b req %b exp 0 0", miss_ready, victim_req); end
        miss_thread = 0; #1;
        checks++; if (victim_req !== 1'b1 || victim_set !== 6'd1) begin errors++; $display("FAIL st_victim got req %b set %0d exp 1 1", victim_req, victim_set); end
        tick(); miss_valid = 0;
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 8) begin tick(); n++; end
        checks++; if (n >= 8) begin errors++; $display("FAIL st_req_timeout got %0d cycles exp <8", n); end
        checks++; if (mem_req_addr !== 32'h1040 || mem_req_thread !== 2'd0) begin errors++; $display("FAIL st_req got addr %h thr %0d exp 1040 0", mem_req_addr, mem_req_thread); end
        tick();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL st_req_drop got %b exp 0", mem_req_valid); end
        mem_rsp_valid = 1; mem_rsp_thread = 0; mem_rsp_data = line_data(9);
        tick(); mem_rsp_valid = 0;
        checks++; if (fill_valid !== 1'b1 || fill_set !== 6'd1 || fill_way !== 2'd2 || fill_tag !== 20'h1) begin
            errors++; $display("FAIL st_fill got v %b set %0d way %0d tag %h exp 1 1 2 1", fill_valid, fill_set, fill_way, fill_tag); end
        checks++; if (fill_data !== line_data(9)) begin errors++; $display("FAIL st_fill_data got %h exp %h", fill_data[31:0], 32'hC0DE0009); end
        checks++; if (update_req_mt !== 1'b1 || update_set_mt !== 6'd1 || update_way_mt !== 2'd2 || update_thread_mt !== 2'd0) begin
            errors++; $display("FAIL st_update got %b %0d %0d %0d exp 1 1 2 0", update_req_mt, update_set_mt, update_way_mt, update_thread_mt); end
        checks++; if (refill_done !== 4'b0001) begin errors++; $display("FAIL st_refill_done got %b exp 0001", refill_done); end
        tick();
        checks++; if (fill_valid !== 1'b0 || refill_done !== 4'b0) begin errors++; $display("FAIL st_one_cycle got %b %b exp 0 0000", fill_valid, refill_done); end
    endtask

    task automatic test_backpressure();
        int n;
        mt_mode = MULTI_THREADED; mem_req_ready = 0;
        miss_valid = 1; miss_thread = 2; miss_addr = 32'h2080; victim_way = 1;
        tick(); miss_valid = 0;
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 8) begin tick(); n++; end
        checks++; if (n >= 8) begin errors++; $display("FAIL bp_req_timeout got %0d cycles exp <8", n); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2080 || mem_req_thread !== 2'd2) begin
                errors++; $display("FAIL bp_hold cyc %0d got v %b addr %h thr %0d exp 1 2080 2", c, mem_req_valid, mem_req_addr, mem_req_thread); end
            tick();
        end
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL bp_entry_busy got %b exp 0", miss_ready); end
        mem_req_ready = 1; tick();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %b exp 0", mem_req_valid); end
        mem_rsp_valid = 1; mem_rsp_thread = 2; mem_rsp_data = line_data(2);
        tick(); mem_rsp_valid = 0;
        checks++; if (fill_valid !== 1'b1 || fill_set !== 6'd2 || fill_way !== 2'd1 || fill_tag !== 20'h2 || refill_done !== 4'b0100) begin
            errors++; $display("FAIL bp_fill got v %b set %0d way %0d tag %h done %b exp 1 2 1 2 0100", fill_valid, fill_set, fill_way, fill_tag, refill_done); end
        tick();
    endtask

    task automatic test_round_robin();
        grants.delete(); mem_req_ready = 1;
        for (int t = 0; t < 4; t++) begin
            miss_valid = 1; miss_thread = 2'(t); miss_addr = 32'h4000 + 32'(t) * 32'h1040; victim_way = 2'(t);
            tick();
        end
        miss_valid = 0;
        repeat (12) tick();
        checks++; if (grants.size() != 4) begin errors++; $display("FAIL rr_count got %0d exp 4", grants.size()); end
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            checks++; if (grants[i] != i) begin errors++; $display("FAIL rr_order idx %0d got %0d exp %0d", i, grants[i], i); end
        end
    endtask

    task automatic test_out_of_order();
        int ord[4] = '{3, 0, 2, 1};
        int k;
        for (int i = 0; i < 4; i++) begin
            k = ord[i];
            mem_rsp_valid = 1; mem_rsp_thread = 2'(k); mem_rsp_data = line_data(k + 16);
            tick();
            checks++; if (fill_valid !== 1'b1 || fill_set !== 6'(k) || fill_way !== 2'(k) || fill_tag !== 20'(4 + k)) begin
                errors++; $display("FAIL ooo_fill thr %0d got v %b set %0d way %0d tag %h", k, fill_valid, fill_set, fill_way, fill_tag); end
            checks++; if (fill_data !== line_data(k + 16) || update_thread_mt !== 2'(k) || refill_done !== (4'b1 << k)) begin
                errors++; $display("FAIL ooo_meta thr %0d got uthr %0d done %b", k, update_thread_mt, refill_done); end
        end
        mem_rsp_valid = 0; tick();
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL ooo_idle got %b exp 0", fill_valid); end
    endtask

    task automatic test_rotation();
        int exp_ord[4] = '{1, 2, 3, 0};
        grants.delete(); mem_req_ready = 0;
        miss_valid = 1; miss_thread = 1; miss_addr = 32'h5000; victim_way = 0;
        tick(); miss_valid = 0; tick();
        for (int i = 1; i < 4; i++) begin
            miss_valid = 1; miss_thread = 2'(exp_ord[i]); miss_addr = 32'h5000 + 32'(i) * 32'h40;
            tick();
        end
        miss_valid = 0; mem_req_ready = 1;
        repeat (12) tick();
        checks++; if (grants.size() != 4) begin errors++; $display("FAIL rot_count got %0d exp 4", grants.size()); end
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            checks++; if (grants[i] != exp_ord[i]) begin errors++; $display("FAIL rot_order idx %0d got %0d exp %0d", i, grants[i], exp_ord[i]); end
        end
        for (int t = 0; t < 4; t++) begin
            mem_rsp_valid = 1; mem_rsp_thread = 2'(t); mem_rsp_data = line_data(t);
            tick();
        end
        mem_rsp_valid = 0; tick();
    endtask

    task automatic test_busy_thread();
        mem_req_ready = 1;
        miss_valid = 1; miss_thread = 1; miss_addr = 32'h6040; victim_way = 3;
        tick(); miss_valid = 0;
        repeat (6) tick();
        miss_valid = 1; miss_thread = 1; miss_addr = 32'h7080; victim_way = 0; #1;
        checks++; if (miss_ready !== 1'b0 || victim_req !== 1'b0) begin errors++; $display("FAIL busy_blocked got ready %b req %b exp 0 0", miss_ready, victim_req); end
        mem_rsp_valid = 1; mem_rsp_thread = 1; mem_rsp_data = line_data(7);
        tick(); mem_rsp_valid = 0; #1;
        checks++; if (fill_valid !== 1'b1 || fill_set !== 6'd1 || fill_way !== 2'd3) begin
            errors++; $display("FAIL busy_fill got v %b set %0d way %0d exp 1 1 3", fill_valid, fill_set, fill_way); end
        checks++; if (miss_ready !== 1'b1 || victim_req !== 1'b1) begin errors++; $display("FAIL busy_remiss got ready %b req %b exp 1 1", miss_ready, victim_req); end
        tick(); miss_valid = 0; tick();
    endtask

    task automatic test_error_reset();
        int n;
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL err_clean got %b exp 0", rsp_error); end
        mem_rsp_valid = 1; mem_rsp_thread = 2; mem_rsp_data = line_data(5);
        tick(); mem_rsp_valid = 0;
        checks++; if (fill_valid !== 1'b0 || refill_done !== 4'b0 || rsp_error !== 1'b1) begin
            errors++; $display("FAIL err_drop got fill %b done %b err %b exp 0 0000 1", fill_valid, refill_done, rsp_error); end
        repeat (3) tick();
        checks++; if (rsp_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", rsp_error); end
        mem_req_ready = 0;
        miss_valid = 1; miss_thread = 3; miss_addr = 32'h8000; victim_way = 1;
        tick(); miss_valid = 0;
        n = 0;
        while (!(mem_req_valid === 1'b1 && mem_req_thread === 2'd3) && n < 8) begin tick(); n++; end
        checks++; if (n >= 8) begin errors++; $display("FAIL err_req_timeout got %0d cycles exp <8", n); end
        rst = 1; tick();
        checks++; if (mem_req_valid !== 1'b0 || rsp_error !== 1'b0) begin errors++; $display("FAIL rst_mid got v %b err %b exp 0 0", mem_req_valid, rsp_error); end
        rst = 0;
        for (int t = 0; t < 4; t++) begin
            miss_thread = 2'(t); #1;
            checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL rst_idle thr %0d got %b exp 1", t, miss_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_st_basic();
        test_backpressure();
        test_round_robin();
        test_out_of_order();
        test_rotation();
        test_busy_thread();
        test_error_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
